modmul120833_feed: RTL
======================

# modmul120833_feed

Streaming operand front-end for the signed mod-120833 reducer. It accepts operand pairs (inA, inB) over a valid/ready handshake and folds out-of-range operands into [-60416, 60416]. It forms the 33-bit signed product that drives the reducer's inZ, then re-aligns the reducer's outZ with a valid/last delay line. Results leave through a credit-protected output FIFO, so the fixed-latency reducer never has to stall.

## Interface
- Q, 120833, modulus.
- QH, 60416, centered bound (Q-1)/2.
- RED_LAT, 3, reducer latency in cycles from inZ to outZ.
- FIFO_DEPTH, 8, output FIFO entries; must be ≥ RED_LAT+3.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts a pair this cycle.
- inA  in  17  signed operand A.
- inB  in  17  signed operand B.
- in_last  in  1  tag carried alongside the pair.
- mulZ  out  33  signed product, wired to the reducer's inZ.
- redZ  in  17  signed reduced value, wired from the reducer's outZ.
- out_valid  out  1  result available at FIFO head.
- out_ready  in  1  consumer takes the head this cycle.
- outC  out  17  signed result ≡ inA·inB (mod Q), in [-QH, QH].
- out_last  out  1  in_last of the pair that produced outC.
- err_range  out  1  sticky: at least one operand needed folding.

## Operation
- Accept: a pair is accepted when in_valid && in_ready at a rising edge.
- S0, operand fold (combinational at accept):
  - x > QH → x−Q.
  - x < −QH → x+Q.
  - Otherwise x is unchanged.
  - Any fold sets err_range.
  - The folded result always lies in [−QH, QH]; −65536 folds to 55297 and 65535 folds to −55298.
- S1: register folded A and B, plus v1 and last1.
- S2: mulZ ← A1·B1, signed 17×17 into 33 bits; |product| ≤ 3,650,093,056, so there is no overflow. Register v2 and last2.
- Delay line: RED_LAT-stage shift of (v, last) starting at v2. The tap at RED_LAT qualifies redZ.
- redZ is ignored whenever the tap's valid is 0; the reducer's internal registers may hold garbage after reset.
- FIFO:
  - Writes (redZ, last) when the qualified tap is valid.
  - Pops when out_valid && out_ready.
  - outC and out_last show the head entry.
  - Strict in-order delivery.
  - Simultaneous write and pop are both performed; occupancy is unchanged.
- Credit counter `cr`:
  - Counts items accepted but not yet popped (pipeline plus FIFO).
  - +1 on accept, −1 on pop; accept and pop in the same cycle leave it unchanged.
  - in_ready = (cr < FIFO_DEPTH), computed from registered state only, with no combinational path from out_ready.
  - This guarantees no FIFO overflow, because the reducer cannot be stalled.
- Boundaries:
  - FIFO full with write and pop in the same cycle: legal, because the credit bound prevents a write when full without a pop.
  - FIFO empty: out_valid=0.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - When in_valid=0 the pipeline still advances and bubbles carry v=0.
  - mulZ holds its last value when v2=0.
- Reset, at assertion, even mid-stream:
  - v1, v2, the delay line, cr, FIFO pointers and count, and err_range clear.
  - In-flight data is discarded.
  - Operand, product and FIFO data registers need no reset.

## Timing
- Reset values: in_ready=1 (cr=0), out_valid=0, outC=0, out_last=0, mulZ=0, err_range=0.
- Latency: a pair accepted at edge E0 gives mulZ valid after E1.
- The reducer outZ appears after E1+RED_LAT (E4).
- The FIFO captures at E5, so out_valid rises after E5: 5 cycles with the defaults.
- Throughput: 1 pair per cycle sustained when out_ready=1. The round trip of 6 is ≤ FIFO_DEPTH, so in_ready never drops.
- With out_ready=0, exactly FIFO_DEPTH pairs are accepted, then in_ready=0 until the first pop. in_ready reasserts the cycle after the pop edge.
- err_range rises the cycle after the accepting edge and stays high until reset.

## Test plan
- Basic: accept (3, 5) at E0 → out_valid after E5, outC=15, out_last echoes in_last, err_range=0.
- Extremes:
  - (60416, 60416) → −30208.
  - (−60416, 2) → 1.
  - (−60416, −60416) → −30208.
  - (0, −60416) → 0.
- Folding:
  - (65535, 1) → −55298 and err_range=1.
  - (−65536, 1) → 55297.
  - (60417, 1) → −60416.
  - err_range stays 1 afterwards.
- Backpressure: hold out_ready=0 and offer 12 pairs (1·1 … 12·1).
  - Exactly 8 are accepted and in_ready=0.
  - Then raise out_ready: outputs 1…12 in order, no loss, no duplicates, and in_ready reasserts one cycle after the first pop.
- Stream: 200 random in-range pairs with out_ready=1 and in_valid=1.
  - One result per cycle after a 5-cycle fill; in_ready stays 1.
  - Results match a reference mod-Q model; random out_ready toggling still gives every result in order.
- Reset mid-stream: assert rst with 5 items in flight.
  - out_valid=0 and in_ready=1 immediately; no stale outputs after release.
  - The next pair (7, 7) → 49 after 5 cycles.

Source files
------------

// File: rtl/modmul120833_feed.sv
// modmul120833_feed
//
// Streaming operand front-end for an external signed mod-120833 reducer.
// Operand pairs arrive over valid/ready. Each operand is folded into
// [-QH, QH], the pair is multiplied into a 33-bit signed product (mulZ ->
// reducer inZ), and the reducer's outZ (redZ) is re-aligned with a valid/last
// delay line. Results are held in an output FIFO. A credit counter stops
// intake before the FIFO could overflow, because the reducer cannot stall.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   operand pair present
//   in_ready   block accepts a pair this cycle (registered state only)
//   inA, inB   17-bit signed operands
//   in_last    tag carried alongside the pair
//   mulZ       33-bit signed product, wired to the reducer's inZ
//   redZ       17-bit signed reduced value, wired from the reducer's outZ
//   out_valid  result available at the FIFO head
//   out_ready  consumer takes the head this cycle
//   outC       17-bit signed result, congruent to inA*inB mod Q, in [-QH, QH]
//   out_last   in_last of the pair that produced outC
//   err_range  sticky flag: at least one operand needed folding
module modmul120833_feed #(
  parameter int Q          = 120833,
  parameter int QH         = 60416,
  parameter int RED_LAT    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [16:0] inA,
  input  logic signed [16:0] inB,
  input  logic               in_last,
  output logic signed [32:0] mulZ,
  input  logic signed [16:0] redZ,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [16:0] outC,
  output logic               out_last,
  output logic               err_range
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CR_W  = $clog2(FIFO_DEPTH + 1);

  // 18 bits hold both the raw operand and Q without overflow.
  localparam logic signed [17:0] Q18  = 18'(Q);
  localparam logic signed [17:0] QH18 = 18'(QH);

  // ---------------------------------------------------------------------------
  // S0: combinational fold of both operands.
  // ---------------------------------------------------------------------------
  logic signed [17:0] a_wide, b_wide, a_sum, b_sum;
  logic signed [16:0] a_fold, b_fold;
  logic               a_oor, b_oor;
  logic               accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    a_wide = {inA[16], inA};
    b_wide = {inB[16], inB};
    a_sum  = a_wide;
    b_sum  = b_wide;
    a_oor  = 1'b0;
    b_oor  = 1'b0;
    if (a_wide > QH18) begin
      a_sum = a_wide - Q18;
      a_oor = 1'b1;
    end else if (a_wide < -QH18) begin
      a_sum = a_wide + Q18;
      a_oor = 1'b1;
    end
    if (b_wide > QH18) begin
      b_sum = b_wide - Q18;
      b_oor = 1'b1;
    end else if (b_wide < -QH18) begin
      b_sum = b_wide + Q18;
      b_oor = 1'b1;
    end
    // The folded value always fits in [-QH, QH], so bit 17 is redundant.
    a_fold = a_sum[16:0];
    b_fold = b_sum[16:0];
  end

  // ---------------------------------------------------------------------------
  // Credit counter: items accepted but not yet popped (pipeline + FIFO).
  // ---------------------------------------------------------------------------
  logic [CR_W-1:0] cr_q, cr_d;
  logic            pop;

  assign in_ready = (cr_q < CR_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    cr_d = cr_q;
    case ({accept, pop})
      2'b10:   cr_d = cr_q + 1'b1;
      2'b01:   cr_d = cr_q - 1'b1;
      default: cr_d = cr_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // S1 / S2 pipeline.
  // ---------------------------------------------------------------------------
  logic signed [16:0] a1_q, b1_q;
  logic               v1_q, last1_q, v2_q, last2_q;
  logic signed [32:0] mulz_q;
  logic signed [33:0] prod_full;
  logic               err_q;

  // 17x17 signed product; |product| <= 3,650,093,056 fits in 33 bits.
  assign prod_full = a1_q * b1_q;

  // NOTE: operand registers carry no reset; their contents are only
  // observed once v1_q qualifies them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a1_q <= a_fold;
      b1_q <= b_fold;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      mulz_q  <= '0;
      cr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      v1_q    <= accept;
      last1_q <= in_last;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      // Bubbles leave the product untouched.
      if (v1_q) mulz_q <= prod_full[32:0];
      cr_q    <= cr_d;
      if (accept && (a_oor || b_oor)) err_q <= 1'b1;
    end
  end

  assign mulZ      = mulz_q;
  assign err_range = err_q;

  // ---------------------------------------------------------------------------
  // Delay line: stage RED_LAT lines up with the reducer's outZ.
  // ---------------------------------------------------------------------------
  logic [RED_LAT-1:0] dv_q, dl_q;
  logic               wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q <= '0;
      dl_q <= '0;
    end else begin
      dv_q[0] <= v2_q;
      dl_q[0] <= last2_q;
      for (int i = 1; i < RED_LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  // redZ is meaningless unless the tap says a real item is there.
  assign wr = dv_q[RED_LAT-1];

  // ---------------------------------------------------------------------------
  // Output FIFO.
  // ---------------------------------------------------------------------------
  logic signed [16:0] mem_c [FIFO_DEPTH];
  logic               mem_l [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CR_W-1:0]    count_q, count_d;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // Gate the head so an empty FIFO shows zeros rather than stale data.
  assign outC      = out_valid ? mem_c[rd_ptr_q] : '0;
  assign out_last  = out_valid ? mem_l[rd_ptr_q] : 1'b0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_c[wr_ptr_q] <= redZ;
      mem_l[wr_ptr_q] <= dl_q[RED_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

endmodule
